bsg_cache_nb_dma_arbiter: RTL and testbench



---
 rtl/bsg_cache_nb_dma_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_bsg_cache_nb_dma_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cache_nb_dma_arbiter.sv
// bsg_cache_nb_dma_arbiter
//
// Purpose:
//   Shares a single DMA-to-wormhole port among num_caches_p non-blocking
//   cache DMA interfaces.
//   - DMA packets are arbitrated round-robin.
//   - Once a write packet is accepted, the write-data channel stays locked
//     to that cache for the full evict block.
//   - Each outgoing packet's MSHR id is extended with the cache index.
//     Returning fill data can then be steered back to the cache that
//     issued the request.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   c_pkt_*                 per-cache DMA packet (valid/yumi)
//   c_wdata_*               per-cache evict data (valid/yumi)
//   c_fdata_*, c_fmshr_id_o fill data broadcast to caches, one-hot valid
//   dma_pkt_*               merged packet toward the wormhole adapter
//   dma_wdata_*             merged evict data toward the wormhole adapter
//   dma_fdata_*, dma_fmshr_id_i
//                           fill data from the wormhole adapter, tagged
//                           with {cache_idx, mshr_id}

module bsg_cache_nb_dma_arbiter #(
    parameter int num_caches_p           = 2,
    parameter int addr_width_p           = 32,
    parameter int block_size_in_words_p  = 8,
    parameter int mshr_els_p             = 4,
    parameter int dma_data_width_p       = 32,
    parameter int block_size_in_bursts_p = 8,
    localparam int lg_mshr_lp    = (mshr_els_p > 1) ? $clog2(mshr_els_p) : 1,
    localparam int lg_nc_lp      = (num_caches_p > 1) ? $clog2(num_caches_p) : 1,
    localparam int lg_burst_lp   = (block_size_in_bursts_p > 1) ? $clog2(block_size_in_bursts_p) : 1,
    localparam int pkt_width_lp  = 1 + block_size_in_words_p + addr_width_p + lg_mshr_lp,
    localparam int opkt_width_lp = pkt_width_lp + lg_nc_lp
) (
    input  logic                                             clk_i,
    input  logic                                             reset_i,

    input  logic [num_caches_p-1:0][pkt_width_lp-1:0]        c_pkt_i,
    input  logic [num_caches_p-1:0]                          c_pkt_v_i,
    output logic [num_caches_p-1:0]                          c_pkt_yumi_o,

    input  logic [num_caches_p-1:0][dma_data_width_p-1:0]    c_wdata_i,
    input  logic [num_caches_p-1:0]                          c_wdata_v_i,
    output logic [num_caches_p-1:0]                          c_wdata_yumi_o,

    output logic [dma_data_width_p-1:0]                      c_fdata_o,
    output logic [lg_mshr_lp-1:0]                            c_fmshr_id_o,
    output logic [num_caches_p-1:0]                          c_fdata_v_o,
    input  logic [num_caches_p-1:0]                          c_fdata_ready_and_i,

    output logic [opkt_width_lp-1:0]                         dma_pkt_o,
    output logic                                             dma_pkt_v_o,
    input  logic                                             dma_pkt_yumi_i,

    output logic [dma_data_width_p-1:0]                      dma_wdata_o,
    output logic                                             dma_wdata_v_o,
    input  logic                                             dma_wdata_yumi_i,

    input  logic [dma_data_width_p-1:0]                      dma_fdata_i,
    input  logic [lg_nc_lp+lg_mshr_lp-1:0]                   dma_fmshr_id_i,
    input  logic                                             dma_fdata_v_i,
    output logic                                             dma_fdata_ready_and_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        WDATA = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [lg_nc_lp-1:0]     grant_q, grant_d;
    logic [lg_nc_lp-1:0]     last_q,  last_d;
    logic [lg_burst_lp-1:0]  count_q, count_d;

    logic [lg_nc_lp-1:0]     win;
    logic                    any_v;
    int                      rr_idx;
    logic [lg_nc_lp-1:0]     rr_sel;

    logic [lg_nc_lp-1:0]     sel;
    logic [pkt_width_lp-1:0] pkt_sel;
    logic                    pkt_v;
    logic                    pkt_hs;
    logic                    pkt_write;
    logic                    wdata_hs;

    logic [lg_nc_lp-1:0]     fill_k;
    logic                    fill_legal;

    // Round-robin search: start just after the last granted cache and take
    // the first valid one, wrapping around.
    always_comb begin
        win    = '0;
        any_v  = 1'b0;
        rr_idx = 0;
        rr_sel = '0;
        for (int i = 1; i <= num_caches_p; i++) begin
            rr_idx = (int'(last_q) + i) % num_caches_p;
            rr_sel = lg_nc_lp'(rr_idx);
            if (!any_v && c_pkt_v_i[rr_sel]) begin
                win   = rr_sel;
                any_v = 1'b1;
            end
        end
    end

    // Datapath muxing and handshakes.
    // In LOCK the offered packet is frozen to grant_q so that the packet
    // presented downstream cannot change under a stalled yumi.
    always_comb begin
        sel       = (state_q == IDLE) ? win : grant_q;
        pkt_sel   = c_pkt_i[sel];
        pkt_write = pkt_sel[pkt_width_lp-1];

        pkt_v = 1'b0;
        case (state_q)
            IDLE:    pkt_v = any_v;
            LOCK:    pkt_v = c_pkt_v_i[grant_q];
            default: pkt_v = 1'b0;
        endcase

        dma_pkt_v_o  = pkt_v & ~reset_i;
        pkt_hs       = dma_pkt_v_o & dma_pkt_yumi_i;
        c_pkt_yumi_o = '0;
        if (pkt_hs) begin
            c_pkt_yumi_o[sel] = 1'b1;
        end

        // Cache index sits between the address and the MSHR id.
        dma_pkt_o = {pkt_sel[pkt_width_lp-1:lg_mshr_lp], sel, pkt_sel[lg_mshr_lp-1:0]};

        dma_wdata_o    = c_wdata_i[grant_q];
        dma_wdata_v_o  = (state_q == WDATA) & c_wdata_v_i[grant_q] & ~reset_i;
        wdata_hs       = dma_wdata_v_o & dma_wdata_yumi_i;
        c_wdata_yumi_o = '0;
        if (wdata_hs) begin
            c_wdata_yumi_o[grant_q] = 1'b1;
        end
    end

    // Next-state logic for the packet/evict FSM.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                if (any_v) begin
                    grant_d = win;
                    if (pkt_hs) begin
                        last_d  = win;
                        state_d = pkt_write ? WDATA : IDLE;
                    end else begin
                        state_d = LOCK;
                    end
                end
            end
            LOCK: begin
                if (pkt_hs) begin
                    last_d  = grant_q;
                    state_d = pkt_write ? WDATA : IDLE;
                end
            end
            WDATA: begin
                if (wdata_hs) begin
                    if (count_q == lg_burst_lp'(block_size_in_bursts_p - 1)) begin
                        count_d = '0;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. The last pointer resets to the final cache so that
    // cache 0 is the first winner.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= lg_nc_lp'(num_caches_p - 1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // Fill steering: the upper bits of the returning id name the owning cache.
    always_comb begin
        fill_k                = dma_fmshr_id_i[lg_nc_lp+lg_mshr_lp-1 -: lg_nc_lp];
        fill_legal            = (32'(fill_k) < 32'(num_caches_p));
        c_fdata_o             = dma_fdata_i;
        c_fmshr_id_o          = dma_fmshr_id_i[lg_mshr_lp-1:0];
        c_fdata_v_o           = '0;
        dma_fdata_ready_and_o = 1'b0;
        if (!reset_i && fill_legal) begin
            c_fdata_v_o[fill_k]   = dma_fdata_v_i;
            dma_fdata_ready_and_o = c_fdata_ready_and_i[fill_k];
        end
    end

    // A fill tagged with a non-existent cache index means the wormhole side
    // has corrupted the id.
    always_ff @(posedge clk_i) begin
        if (!reset_i && dma_fdata_v_i) begin
            assert (fill_legal)
                else $error("bsg_cache_nb_dma_arbiter: fill cache index %0d out of range", fill_k);
        end
    end

endmodule

// File: tb/tb_bsg_cache_nb_dma_arbiter.sv
// tb_bsg_cache_nb_dma_arbiter
//
// Purpose:
//   Directed, self-checking bench for bsg_cache_nb_dma_arbiter with two
//   caches and four MSHRs.
//   Expected packets and evict beats are queued when stimulus is driven
//   and compared when the DUT completes the matching handshake.

module tb_bsg_cache_nb_dma_arbiter;

    localparam int NC     = 2;
    localparam int AW     = 16;
    localparam int WORDS  = 8;
    localparam int MSHR   = 4;
    localparam int DW     = 32;
    localparam int BURSTS = 8;
    localparam int LGM    = 2;
    localparam int LGN    = 1;
    localparam int PW     = 1 + WORDS + AW + LGM;
    localparam int OPW    = PW + LGN;

    logic                     clk = 1'b0;
    logic                     reset_i;
    logic [NC-1:0][PW-1:0]    c_pkt_i;
    logic [NC-1:0]            c_pkt_v_i;
    logic [NC-1:0]            c_pkt_yumi_o;
    logic [NC-1:0][DW-1:0]    c_wdata_i;
    logic [NC-1:0]            c_wdata_v_i;
    logic [NC-1:0]            c_wdata_yumi_o;
    logic [DW-1:0]            c_fdata_o;
    logic [LGM-1:0]           c_fmshr_id_o;
    logic [NC-1:0]            c_fdata_v_o;
    logic [NC-1:0]            c_fdata_ready_and_i;
    logic [OPW-1:0]           dma_pkt_o;
    logic                     dma_pkt_v_o;
    logic                     dma_pkt_yumi_i;
    logic [DW-1:0]            dma_wdata_o;
    logic                     dma_wdata_v_o;
    logic                     dma_wdata_yumi_i;
    logic [DW-1:0]            dma_fdata_i;
    logic [LGN+LGM-1:0]       dma_fmshr_id_i;
    logic                     dma_fdata_v_i;
    logic                     dma_fdata_ready_and_o;

    int checks   = 0;
    int failures = 0;

    logic [OPW-1:0] pktQ[$];
    logic [DW-1:0]  wdQ[$];

    always #5 clk = ~clk;

    bsg_cache_nb_dma_arbiter #(
        .num_caches_p           (NC),
        .addr_width_p           (AW),
        .block_size_in_words_p  (WORDS),
        .mshr_els_p             (MSHR),
        .dma_data_width_p       (DW),
        .block_size_in_bursts_p (BURSTS)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset_i),
        .c_pkt_i               (c_pkt_i),
        .c_pkt_v_i             (c_pkt_v_i),
        .c_pkt_yumi_o          (c_pkt_yumi_o),
        .c_wdata_i             (c_wdata_i),
        .c_wdata_v_i           (c_wdata_v_i),
        .c_wdata_yumi_o        (c_wdata_yumi_o),
        .c_fdata_o             (c_fdata_o),
        .c_fmshr_id_o          (c_fmshr_id_o),
        .c_fdata_v_o           (c_fdata_v_o),
        .c_fdata_ready_and_i   (c_fdata_ready_and_i),
        .dma_pkt_o             (dma_pkt_o),
        .dma_pkt_v_o           (dma_pkt_v_o),
        .dma_pkt_yumi_i        (dma_pkt_yumi_i),
        .dma_wdata_o           (dma_wdata_o),
        .dma_wdata_v_o         (dma_wdata_v_o),
        .dma_wdata_yumi_i      (dma_wdata_yumi_i),
        .dma_fdata_i           (dma_fdata_i),
        .dma_fmshr_id_i        (dma_fmshr_id_i),
        .dma_fdata_v_i         (dma_fdata_v_i),
        .dma_fdata_ready_and_o (dma_fdata_ready_and_o)
    );

    function automatic logic [PW-1:0] mkPkt(input logic w, input logic [WORDS-1:0] m,
                                            input logic [AW-1:0] a, input logic [LGM-1:0] id);
        return {w, m, a, id};
    endfunction

    function automatic logic [OPW-1:0] mkOpkt(input logic w, input logic [WORDS-1:0] m,
                                              input logic [AW-1:0] a, input logic [LGN-1:0] c,
                                              input logic [LGM-1:0] id);
        return {w, m, a, c, id};
    endfunction

    // Drive the handshake inputs for this cycle, then settle before sampling.
    task automatic applyStimulus(input logic [NC-1:0] pktV, input logic pktYumi, input logic wYumi);
        c_pkt_v_i        = pktV;
        dma_pkt_yumi_i   = pktYumi;
        dma_wdata_yumi_i = wYumi;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
            else begin
                failures++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            end
    endtask

    // Pop and compare the scoreboard whenever a handshake completes.
    task automatic observe(input string tag);
        if (dma_pkt_v_o && dma_pkt_yumi_i) begin
            if (pktQ.size() == 0) checkOutput({tag, "_pkt_unexpected"}, 64'(pktQ.size()), 64'd1);
            else                  checkOutput({tag, "_pkt_sb"}, 64'(dma_pkt_o), 64'(pktQ.pop_front()));
        end
        if (dma_wdata_v_o && dma_wdata_yumi_i) begin
            if (wdQ.size() == 0) checkOutput({tag, "_wd_unexpected"}, 64'(wdQ.size()), 64'd1);
            else                 checkOutput({tag, "_wd_sb"}, 64'(dma_wdata_o), 64'(wdQ.pop_front()));
        end
    endtask

    initial begin
        int beat;
        logic [NC-1:0] expGrant;

        reset_i             = 1'b1;
        c_pkt_i             = '0;
        c_pkt_v_i           = '0;
        c_wdata_i           = '0;
        c_wdata_v_i         = '0;
        c_fdata_ready_and_i = '0;
        dma_pkt_yumi_i      = 1'b0;
        dma_wdata_yumi_i    = 1'b0;
        dma_fdata_i         = '0;
        dma_fmshr_id_i      = '0;
        dma_fdata_v_i       = 1'b0;

        // Reset: outputs are gated even with every request active.
        @(negedge clk);
        c_wdata_v_i         = 2'b11;
        dma_fdata_v_i       = 1'b1;
        dma_fmshr_id_i      = 3'b1_00;
        c_fdata_ready_and_i = 2'b11;
        applyStimulus(2'b11, 1'b1, 1'b1);
        checkOutput("rst_pkt_v", 64'(dma_pkt_v_o), 64'd0);
        checkOutput("rst_pkt_yumi", 64'(c_pkt_yumi_o), 64'd0);
        checkOutput("rst_wd_v", 64'(dma_wdata_v_o), 64'd0);
        checkOutput("rst_wd_yumi", 64'(c_wdata_yumi_o), 64'd0);
        checkOutput("rst_f_v", 64'(c_fdata_v_o), 64'd0);
        checkOutput("rst_f_rdy", 64'(dma_fdata_ready_and_o), 64'd0);

        // Test 1: single cache1 read, zero-latency issue and id extension.
        @(negedge clk);
        reset_i             = 1'b0;
        c_wdata_v_i         = '0;
        dma_fdata_v_i       = 1'b0;
        c_fdata_ready_and_i = '0;
        c_pkt_i[1]          = mkPkt(1'b0, 8'hFF, 16'h1234, 2'd2);
        pktQ.push_back(mkOpkt(1'b0, 8'hFF, 16'h1234, 1'b1, 2'd2));
        applyStimulus(2'b10, 1'b1, 1'b0);
        checkOutput("t1_pkt_v", 64'(dma_pkt_v_o), 64'd1);
        checkOutput("t1_yumi", 64'(c_pkt_yumi_o), 64'b10);
        checkOutput("t1_id", 64'(dma_pkt_o[2:0]), 64'b110);
        observe("t1");

        // Test 2: both caches read continuously; grants alternate 0,1,0,1.
        c_pkt_i[0] = mkPkt(1'b0, 8'h11, 16'hA000, 2'd0);
        c_pkt_i[1] = mkPkt(1'b0, 8'h22, 16'hB000, 2'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            expGrant = (i % 2 == 0) ? 2'b01 : 2'b10;
            if (i % 2 == 0) pktQ.push_back(mkOpkt(1'b0, 8'h11, 16'hA000, 1'b0, 2'd0));
            else            pktQ.push_back(mkOpkt(1'b0, 8'h22, 16'hB000, 1'b1, 2'd3));
            applyStimulus(2'b11, 1'b1, 1'b0);
            checkOutput("t2_grant", 64'(c_pkt_yumi_o), 64'(expGrant));
            observe("t2");
        end

        // Test 3: stalled cache1 packet stays locked while cache0 arrives.
        c_pkt_i[0] = mkPkt(1'b0, 8'h33, 16'hC000, 2'd1);
        c_pkt_i[1] = mkPkt(1'b0, 8'h44, 16'hD000, 2'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus((i == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0);
            checkOutput("t3_lock_pkt", 64'(dma_pkt_o), 64'(mkOpkt(1'b0, 8'h44, 16'hD000, 1'b1, 2'd2)));
            checkOutput("t3_lock_yumi", 64'(c_pkt_yumi_o), 64'd0);
        end
        @(negedge clk);
        pktQ.push_back(mkOpkt(1'b0, 8'h44, 16'hD000, 1'b1, 2'd2));
        applyStimulus(2'b11, 1'b1, 1'b0);
        checkOutput("t3_rel_yumi", 64'(c_pkt_yumi_o), 64'b10);
        observe("t3");
        @(negedge clk);
        pktQ.push_back(mkOpkt(1'b0, 8'h33, 16'hC000, 1'b0, 2'd1));
        applyStimulus(2'b01, 1'b1, 1'b0);
        checkOutput("t3_next_yumi", 64'(c_pkt_yumi_o), 64'b01);
        observe("t3");

        // Point the round-robin at cache1 so cache0 wins the next contest.
        @(negedge clk);
        c_pkt_i[1] = mkPkt(1'b0, 8'h55, 16'hE000, 2'd0);
        pktQ.push_back(mkOpkt(1'b0, 8'h55, 16'hE000, 1'b1, 2'd0));
        applyStimulus(2'b10, 1'b1, 1'b0);
        checkOutput("t4_pre_yumi", 64'(c_pkt_yumi_o), 64'b10);
        observe("t4pre");

        // Test 4: cache0 evict of 8 beats with cache1 read pending.
        @(negedge clk);
        c_pkt_i[0] = mkPkt(1'b1, 8'hFF, 16'h4000, 2'd3);
        c_pkt_i[1] = mkPkt(1'b0, 8'h0F, 16'h5000, 2'd1);
        pktQ.push_back(mkOpkt(1'b1, 8'hFF, 16'h4000, 1'b0, 2'd3));
        for (int b = 0; b < BURSTS; b++) wdQ.push_back(32'hA000_0000 + DW'(b));
        applyStimulus(2'b11, 1'b1, 1'b0);
        checkOutput("t4_wr_yumi", 64'(c_pkt_yumi_o), 64'b01);
        observe("t4");
        beat = 0;
        for (int cyc = 0; cyc < 40 && beat < BURSTS; cyc++) begin
            @(negedge clk);
            c_wdata_i[0] = 32'hA000_0000 + DW'(beat);
            c_wdata_i[1] = 32'hDEAD_BEEF;
            c_wdata_v_i  = 2'b11;
            applyStimulus(2'b10, 1'b1, cyc[0]);
            checkOutput("t4_pkt_v", 64'(dma_pkt_v_o), 64'd0);
            checkOutput("t4_pkt_yumi", 64'(c_pkt_yumi_o), 64'd0);
            checkOutput("t4_wd_v", 64'(dma_wdata_v_o), 64'd1);
            checkOutput("t4_wd_yumi", 64'(c_wdata_yumi_o), 64'({1'b0, cyc[0]}));
            observe("t4");
            if (cyc[0]) beat++;
        end
        checkOutput("t4_beats", 64'(beat), 64'(BURSTS));
        @(negedge clk);
        pktQ.push_back(mkOpkt(1'b0, 8'h0F, 16'h5000, 1'b1, 2'd1));
        applyStimulus(2'b10, 1'b1, 1'b1);
        checkOutput("t4_after_v", 64'(dma_pkt_v_o), 64'd1);
        checkOutput("t4_after_yumi", 64'(c_pkt_yumi_o), 64'b10);
        checkOutput("t4_after_wdyumi", 64'(c_wdata_yumi_o), 64'd0);
        observe("t4");

        // Test 5: fills steered by the upper id bit, ready taken from the owner.
        @(negedge clk);
        c_wdata_v_i    = '0;
        dma_fdata_i    = 32'hF111_0001;
        dma_fmshr_id_i = 3'b1_01;
        dma_fdata_v_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            c_fdata_ready_and_i = (i == 0) ? 2'b00 : (i == 1) ? 2'b01 : 2'b10;
            applyStimulus(2'b00, 1'b0, 1'b0);
            checkOutput("t5_f_v", 64'(c_fdata_v_o), 64'b10);
            checkOutput("t5_f_rdy", 64'(dma_fdata_ready_and_o), (i == 2) ? 64'd1 : 64'd0);
            checkOutput("t5_f_mshr", 64'(c_fmshr_id_o), 64'd1);
            checkOutput("t5_f_data", 64'(c_fdata_o), 64'hF111_0001);
        end
        @(negedge clk);
        dma_fdata_i         = 32'hF000_0003;
        dma_fmshr_id_i      = 3'b0_11;
        c_fdata_ready_and_i = 2'b01;
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("t5_f0_v", 64'(c_fdata_v_o), 64'b01);
        checkOutput("t5_f0_rdy", 64'(dma_fdata_ready_and_o), 64'd1);
        checkOutput("t5_f0_mshr", 64'(c_fmshr_id_o), 64'd3);
        @(negedge clk);
        dma_fdata_v_i = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("t5_f_idle", 64'(c_fdata_v_o), 64'd0);

        // Test 6: reset in the middle of an evict burst.
        @(negedge clk);
        c_pkt_i[0] = mkPkt(1'b1, 8'hF0, 16'h6000, 2'd2);
        pktQ.push_back(mkOpkt(1'b1, 8'hF0, 16'h6000, 1'b0, 2'd2));
        for (int b = 0; b < BURSTS; b++) wdQ.push_back(32'hB000_0000 + DW'(b));
        applyStimulus(2'b01, 1'b1, 1'b0);
        checkOutput("t6_wr_yumi", 64'(c_pkt_yumi_o), 64'b01);
        observe("t6");
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            c_wdata_i[0] = 32'hB000_0000 + DW'(b);
            c_wdata_v_i  = 2'b01;
            applyStimulus(2'b00, 1'b0, 1'b1);
            checkOutput("t6_wd_yumi", 64'(c_wdata_yumi_o), 64'b01);
            observe("t6");
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset_i             = 1'b1;
            c_wdata_i[0]        = 32'hB000_0003;
            c_wdata_v_i         = 2'b11;
            dma_fdata_v_i       = 1'b1;
            dma_fmshr_id_i      = 3'b1_00;
            c_fdata_ready_and_i = 2'b11;
            applyStimulus(2'b11, 1'b1, 1'b1);
            checkOutput("t6_rst_pkt_v", 64'(dma_pkt_v_o), 64'd0);
            checkOutput("t6_rst_pkt_yumi", 64'(c_pkt_yumi_o), 64'd0);
            checkOutput("t6_rst_wd_v", 64'(dma_wdata_v_o), 64'd0);
            checkOutput("t6_rst_wd_yumi", 64'(c_wdata_yumi_o), 64'd0);
            checkOutput("t6_rst_f_v", 64'(c_fdata_v_o), 64'd0);
            checkOutput("t6_rst_f_rdy", 64'(dma_fdata_ready_and_o), 64'd0);
        end
        // The partially sent block is abandoned.
        wdQ.delete();
        @(negedge clk);
        reset_i             = 1'b0;
        c_wdata_v_i         = '0;
        dma_fdata_v_i       = 1'b0;
        c_fdata_ready_and_i = '0;
        c_pkt_i[0]          = mkPkt(1'b0, 8'h01, 16'h7000, 2'd1);
        c_pkt_i[1]          = mkPkt(1'b0, 8'h02, 16'h8000, 2'd2);
        pktQ.push_back(mkOpkt(1'b0, 8'h01, 16'h7000, 1'b0, 2'd1));
        applyStimulus(2'b11, 1'b1, 1'b0);
        checkOutput("t6_post_v", 64'(dma_pkt_v_o), 64'd1);
        checkOutput("t6_post_yumi", 64'(c_pkt_yumi_o), 64'b01);
        checkOutput("t6_post_wd_v", 64'(dma_wdata_v_o), 64'd0);
        observe("t6");
        @(negedge clk);
        pktQ.push_back(mkOpkt(1'b0, 8'h02, 16'h8000, 1'b1, 2'd2));
        applyStimulus(2'b10, 1'b1, 1'b0);
        checkOutput("t6_post2_yumi", 64'(c_pkt_yumi_o), 64'b10);
        observe("t6");

        @(negedge clk);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("end_pktq_empty", 64'(pktQ.size()), 64'd0);
        checkOutput("end_wdq_empty", 64'(wdQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
